toy_trap_seq: RTL and testbench
===============================

# toy_trap_seq

Trap-entry sequencer that sits directly downstream of the trap/debug arbitration stage. It accepts one normal trap or one debug-entry request at a time and flushes the pipeline. It then writes the architectural CSRs in a fixed order over the single CSR write port, and finally redirects fetch to the handler or debug vector. Only one trap is in flight; further requests are back-pressured through `trap_rdy` and `debug_rdy`.

## Interface
Parameters:
- `MTVEC_VECTORED`, default 0: when 1 and `mtvec[1:0]==2'b01`, the redirect target is base + 4·cause. When 0, the target is always the base.
- Widths `ADDR_WIDTH`, `INST_WIDTH`, `REG_WIDTH` (all 32) come from `toy_pack`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `trap_vld` in 1 / `trap_rdy` out 1: normal-trap handshake.
- `trap_pc` in ADDR_WIDTH: faulting pc.
- `trap_cause` in 6: mcause code.
- `trap_extra_info` in INST_WIDTH: mtval value.
- `trap_indebug` in 1: the trap occurred while in debug mode.
- `debug_vld` in 1 / `debug_rdy` out 1: debug-entry handshake; upstream holds `debug_vld` until accepted.
- `debug_cause` in 3: DM cause code.
- `debug_pc` in ADDR_WIDTH: dpc value.
- `csr_mtvec` in REG_WIDTH: current mtvec.
- `csr_mstatus` in REG_WIDTH: current mstatus.
- `csr_dcsr` in REG_WIDTH: current dcsr.
- `csr_wr_en` out 1, `csr_wr_addr` out 12, `csr_wr_data` out REG_WIDTH, `csr_wr_rdy` in 1: CSR write port.
- `flush` out 1: one-cycle pipeline kill.
- `redirect_vld` out 1, `redirect_pc` out ADDR_WIDTH, `redirect_rdy` in 1: fetch redirect handshake.
- `debug_mode_set` out 1: one-cycle pulse on completion of debug entry.
- `busy` out 1: asserted whenever the state is not IDLE.

## Operation
- States: IDLE, FLUSH, W_EPC, W_CAUSE, W_TVAL, W_STAT, W_DPC, W_DCSR, REDIR.
- In IDLE:
  - `debug_rdy = 1`.
  - `trap_rdy = !debug_vld`, so debug wins when both requests arrive together.
- On accept, the request fields are captured into holding registers and the state moves to FLUSH. `flush` is high for exactly that one cycle.
- FLUSH routing:
  - Normal trap: FLUSH→W_EPC→W_CAUSE→W_TVAL→W_STAT→REDIR.
  - `trap_indebug=1`: FLUSH→REDIR directly, with no CSR writes. Target is `DM_EXCP_ADDR`.
  - Debug entry: FLUSH→W_DPC→W_DCSR→REDIR. Target is `DM_HALT_ADDR`.
- Write data per state:
  - W_EPC: `mepc = {pc[31:1],1'b0}`.
  - W_CAUSE: `mcause = {26'b0,cause}`.
  - W_TVAL: `mtval = extra_info`.
  - W_STAT: `mstatus` with MPIE←MIE, MIE←0, MPP←2'b11, all other bits unchanged. The value is read from `csr_mstatus` during W_STAT.
  - W_DPC: `dpc = debug_pc`.
  - W_DCSR: `dcsr` with [8:6]←debug_cause, [1:0]←2'b11, other bits unchanged.
- Each W_* state drives `csr_wr_en=1` and holds until `csr_wr_rdy`, then advances.
- REDIR:
  - `redirect_vld=1` until `redirect_rdy`, then the state returns to IDLE.
  - Normal target is `{csr_mtvec[31:2],2'b00}`, plus `cause<<2` when vectored. Computed in 32 bits; carries beyond 32 bits are dropped.
  - `csr_mtvec` is sampled in REDIR.
- `debug_mode_set` pulses in the cycle the debug-entry REDIR handshake completes.

## Timing
- Reset values: all outputs 0 except `trap_rdy=1` and `debug_rdy=1`; state is IDLE.
- Zero-stall normal trap accepted at cycle T:
  - `flush` at T+1.
  - `csr_wr_en` at T+2..T+5.
  - `redirect_vld` at T+6.
  - `trap_rdy` high again at T+7.
- Debug entry at T: `redirect_vld` at T+4.
- In-debug trap at T: `redirect_vld` at T+2.
- All outputs are registered-state decodes. `trap_rdy`/`debug_rdy` are combinational from state and `debug_vld` only.
- Stalls: `csr_wr_rdy=0` or `redirect_rdy=0` holds the current state with outputs stable. There is no timeout.
- Requests arriving while `busy` are not accepted and cause no side effects.
- Reset asserted mid-sequence: the next cycle is IDLE, with no partial redirect and no further writes. CSR writes already issued are not undone.

## Structure
- Add to `toy_pack`:
  - The `trap_seq_state_e` enum.
  - CSR address constants `CSR_MEPC`, `CSR_MCAUSE`, `CSR_MTVAL`, `CSR_MSTATUS`, `CSR_DPC`, `CSR_DCSR`.
  - `DM_HALT_ADDR`, `DM_EXCP_ADDR`.
  - mstatus bit indices MIE=3, MPIE=7, MPP=12:11.
- Flat module with no sub-modules: one FSM, holding registers and a write-data mux.

## Test plan
- Trap pc=0x8000_0104, cause=2, info=0xDEAD_BEEF, mtvec=0x8000_1000, mstatus=0x8 → writes in order: 0x341←0x8000_0104, 0x342←0x2, 0x343←0xDEAD_BEEF, 0x300←0x1880; redirect 0x8000_1000 at T+6.
- Same trap with MTVEC_VECTORED=1, mtvec=0x8000_1001, cause=2 → redirect 0x8000_1008.
- `trap_vld` and `debug_vld` together, debug_cause=3, debug_pc=0x200, dcsr=0x4000_0000 → `trap_rdy=0`; 0x7B1←0x200, 0x7B0←0x4000_00C3; redirect DM_HALT_ADDR; `debug_mode_set` pulses once.
- `trap_indebug=1` → `flush`, zero CSR writes, redirect DM_EXCP_ADDR at T+2.
- `csr_wr_rdy` low 3 cycles in W_CAUSE and `redirect_rdy` low 2 cycles → outputs hold stable; redirect at T+11.
- `rst_n` low during W_TVAL → IDLE next cycle, `redirect_vld` never asserted; a new trap is accepted cleanly afterwards.

Source files
------------

// File: rtl/toy_pack.sv
// Shared widths, CSR addresses, debug vectors and FSM types for the trap-entry path.
package toy_pack;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned REG_WIDTH  = 32;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_DCSR    = 12'h7B0;
  localparam logic [11:0] CSR_DPC     = 12'h7B1;

  localparam logic [31:0] DM_HALT_ADDR = 32'h0000_0800;
  localparam logic [31:0] DM_EXCP_ADDR = 32'h0000_0808;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    TS_IDLE,
    TS_FLUSH,
    TS_W_EPC,
    TS_W_CAUSE,
    TS_W_TVAL,
    TS_W_STAT,
    TS_W_DPC,
    TS_W_DCSR,
    TS_REDIR
  } trap_seq_state_e;

  typedef enum logic [1:0] {
    REQ_TRAP,
    REQ_TRAP_INDEBUG,
    REQ_DEBUG
  } trap_req_e;

endpackage

// File: rtl/toy_trap_seq.sv
// Trap/debug entry sequencer: flush, ordered CSR writes over one port, then fetch redirect.
module toy_trap_seq
  import toy_pack::*;
#(
  parameter bit MTVEC_VECTORED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trap_vld,
  output logic                  trap_rdy,
  input  logic [ADDR_WIDTH-1:0] trap_pc,
  input  logic [5:0]            trap_cause,
  input  logic [INST_WIDTH-1:0] trap_extra_info,
  input  logic                  trap_indebug,
  input  logic                  debug_vld,
  output logic                  debug_rdy,
  input  logic [2:0]            debug_cause,
  input  logic [ADDR_WIDTH-1:0] debug_pc,
  input  logic [REG_WIDTH-1:0]  csr_mtvec,
  input  logic [REG_WIDTH-1:0]  csr_mstatus,
  input  logic [REG_WIDTH-1:0]  csr_dcsr,
  output logic                  csr_wr_en,
  output logic [11:0]           csr_wr_addr,
  output logic [REG_WIDTH-1:0]  csr_wr_data,
  input  logic                  csr_wr_rdy,
  output logic                  flush,
  output logic                  redirect_vld,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  redirect_rdy,
  output logic                  debug_mode_set,
  output logic                  busy
);

  trap_seq_state_e state_q, state_d;
  trap_req_e       req_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [5:0]            cause_q;
  logic [INST_WIDTH-1:0] info_q;
  logic [2:0]            dcause_q;

  logic accept_dbg, accept_trap;
  logic [ADDR_WIDTH-1:0] trap_target;

  assign accept_dbg  = (state_q == TS_IDLE) && debug_vld;
  assign accept_trap = (state_q == TS_IDLE) && trap_vld && !debug_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= TS_IDLE;
    else        state_q <= state_d;
  end

  // dpc shares the pc holding register; only one request kind is ever in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q    <= REQ_TRAP;
      pc_q     <= '0;
      cause_q  <= '0;
      info_q   <= '0;
      dcause_q <= '0;
    end else if (accept_dbg) begin
      req_q    <= REQ_DEBUG;
      pc_q     <= debug_pc;
      dcause_q <= debug_cause;
    end else if (accept_trap) begin
      req_q   <= trap_indebug ? REQ_TRAP_INDEBUG : REQ_TRAP;
      pc_q    <= trap_pc;
      cause_q <= trap_cause;
      info_q  <= trap_extra_info;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TS_IDLE:    if (accept_dbg || accept_trap) state_d = TS_FLUSH;
      TS_FLUSH: begin
        unique case (req_q)
          REQ_DEBUG:        state_d = TS_W_DPC;
          REQ_TRAP_INDEBUG: state_d = TS_REDIR;
          default:          state_d = TS_W_EPC;
        endcase
      end
      TS_W_EPC:   if (csr_wr_rdy) state_d = TS_W_CAUSE;
      TS_W_CAUSE: if (csr_wr_rdy) state_d = TS_W_TVAL;
      TS_W_TVAL:  if (csr_wr_rdy) state_d = TS_W_STAT;
      TS_W_STAT:  if (csr_wr_rdy) state_d = TS_REDIR;
      TS_W_DPC:   if (csr_wr_rdy) state_d = TS_W_DCSR;
      TS_W_DCSR:  if (csr_wr_rdy) state_d = TS_REDIR;
      TS_REDIR:   if (redirect_rdy) state_d = TS_IDLE;
      default:    state_d = TS_IDLE;
    endcase
  end

  always_comb begin
    trap_target = {csr_mtvec[31:2], 2'b00};
    if (MTVEC_VECTORED && (csr_mtvec[1:0] == 2'b01))
      trap_target = trap_target + {24'b0, cause_q, 2'b00};
  end

  always_comb begin
    trap_rdy       = 1'b0;
    debug_rdy      = 1'b0;
    flush          = 1'b0;
    csr_wr_en      = 1'b0;
    csr_wr_addr    = '0;
    csr_wr_data    = '0;
    redirect_vld   = 1'b0;
    redirect_pc    = '0;
    debug_mode_set = 1'b0;
    busy           = (state_q != TS_IDLE);
    unique case (state_q)
      TS_IDLE: begin
        debug_rdy = 1'b1;
        trap_rdy  = !debug_vld;
      end
      TS_FLUSH: flush = 1'b1;
      TS_W_EPC: begin
        csr_wr_en   = 1'b1;
        csr_wr_addr = CSR_MEPC;
        csr_wr_data = {pc_q[31:1], 1'b0};
      end
      TS_W_CAUSE: begin
        csr_wr_en   = 1'b1;
        csr_wr_addr = CSR_MCAUSE;
        csr_wr_data = {26'b0, cause_q};
      end
      TS_W_TVAL: begin
        csr_wr_en   = 1'b1;
        csr_wr_addr = CSR_MTVAL;
        csr_wr_data = info_q;
      end
      TS_W_STAT: begin
        csr_wr_en                                   = 1'b1;
        csr_wr_addr                                 = CSR_MSTATUS;
        csr_wr_data                                 = csr_mstatus;
        csr_wr_data[MSTATUS_MPIE]                   = csr_mstatus[MSTATUS_MIE];
        csr_wr_data[MSTATUS_MIE]                    = 1'b0;
        csr_wr_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
      end
      TS_W_DPC: begin
        csr_wr_en   = 1'b1;
        csr_wr_addr = CSR_DPC;
        csr_wr_data = pc_q;
      end
      TS_W_DCSR: begin
        csr_wr_en        = 1'b1;
        csr_wr_addr      = CSR_DCSR;
        csr_wr_data      = csr_dcsr;
        csr_wr_data[8:6] = dcause_q;
        csr_wr_data[1:0] = 2'b11;
      end
      TS_REDIR: begin
        redirect_vld = 1'b1;
        unique case (req_q)
          REQ_DEBUG:        redirect_pc = DM_HALT_ADDR;
          REQ_TRAP_INDEBUG: redirect_pc = DM_EXCP_ADDR;
          default:          redirect_pc = trap_target;
        endcase
        debug_mode_set = (req_q == REQ_DEBUG) && redirect_rdy;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_toy_trap_seq.sv
// Cycle-accurate check of toy_trap_seq (scalar and vectored mtvec) against a transaction-level model.
module tb_toy_trap_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, trap_vld, trap_indebug, debug_vld, csr_wr_rdy, redirect_rdy;
  logic [31:0] trap_pc, trap_extra_info, debug_pc, csr_mtvec, csr_mstatus, csr_dcsr;
  logic [5:0]  trap_cause;
  logic [2:0]  debug_cause;

  logic        trap_rdy_a, debug_rdy_a, wen_a, flush_a, rvld_a, dms_a, busy_a;
  logic [11:0] waddr_a;
  logic [31:0] wdata_a, rpc_a;
  logic        trap_rdy_v, debug_rdy_v, wen_v, flush_v, rvld_v, dms_v, busy_v;
  logic [11:0] waddr_v;
  logic [31:0] wdata_v, rpc_v;

  toy_trap_seq dut (
    .clk(clk), .rst_n(rst_n),
    .trap_vld(trap_vld), .trap_rdy(trap_rdy_a), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_extra_info(trap_extra_info), .trap_indebug(trap_indebug),
    .debug_vld(debug_vld), .debug_rdy(debug_rdy_a), .debug_cause(debug_cause), .debug_pc(debug_pc),
    .csr_mtvec(csr_mtvec), .csr_mstatus(csr_mstatus), .csr_dcsr(csr_dcsr),
    .csr_wr_en(wen_a), .csr_wr_addr(waddr_a), .csr_wr_data(wdata_a), .csr_wr_rdy(csr_wr_rdy),
    .flush(flush_a), .redirect_vld(rvld_a), .redirect_pc(rpc_a), .redirect_rdy(redirect_rdy),
    .debug_mode_set(dms_a), .busy(busy_a)
  );

  toy_trap_seq #(.MTVEC_VECTORED(1'b1)) dut_v (
    .clk(clk), .rst_n(rst_n),
    .trap_vld(trap_vld), .trap_rdy(trap_rdy_v), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_extra_info(trap_extra_info), .trap_indebug(trap_indebug),
    .debug_vld(debug_vld), .debug_rdy(debug_rdy_v), .debug_cause(debug_cause), .debug_pc(debug_pc),
    .csr_mtvec(csr_mtvec), .csr_mstatus(csr_mstatus), .csr_dcsr(csr_dcsr),
    .csr_wr_en(wen_v), .csr_wr_addr(waddr_v), .csr_wr_data(wdata_v), .csr_wr_rdy(csr_wr_rdy),
    .flush(flush_v), .redirect_vld(rvld_v), .redirect_pc(rpc_v), .redirect_rdy(redirect_rdy),
    .debug_mode_set(dms_v), .busy(busy_v)
  );

  typedef struct packed {
    logic        trap_rdy;
    logic        debug_rdy;
    logic        flush;
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        rvld;
    logic [31:0] rpc;
    logic        dms;
    logic        busy;
  } obs_t;

  typedef struct packed {
    logic tv;
    logic dv;
    logic crdy;
    logic rrdy;
    logic rstn;
    logic noise;
  } stim_t;

  obs_t  exp_a[$];
  obs_t  exp_v[$];
  stim_t stim_q[$];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // current transaction: kind 0 trap, 1 trap in debug, 2 debug entry, 3 trap+debug together
  int          t_kind;
  logic [31:0] t_pc, t_info, t_dpc, t_mtvec, t_mstatus, t_dcsr;
  logic [5:0]  t_cause;
  logic [2:0]  t_dcause;
  int unsigned wst[4];
  int unsigned t_rs;
  int          t_rst_at;

  task automatic set_txn(input int kind, input logic [31:0] pc, input logic [5:0] cause,
                         input logic [31:0] info, input logic [2:0] dcause, input logic [31:0] dpc,
                         input logic [31:0] mtvec, input logic [31:0] mstatus, input logic [31:0] dcsr);
    t_kind = kind; t_pc = pc; t_cause = cause; t_info = info; t_dcause = dcause; t_dpc = dpc;
    t_mtvec = mtvec; t_mstatus = mstatus; t_dcsr = dcsr;
    for (int i = 0; i < 4; i++) wst[i] = 0;
    t_rs = 0;
    t_rst_at = -1;
  endtask

  function automatic obs_t sample_a();
    return '{trap_rdy_a, debug_rdy_a, flush_a, wen_a, waddr_a, wdata_a, rvld_a, rpc_a, dms_a, busy_a};
  endfunction

  function automatic obs_t sample_v();
    return '{trap_rdy_v, debug_rdy_v, flush_v, wen_v, waddr_v, wdata_v, rvld_v, rpc_v, dms_v, busy_v};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_txn(input string name);
    logic [11:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] tgt_a, tgt_v, base, mst, dcs;
    obs_t  o, ov;
    stim_t s;
    exp_a.delete(); exp_v.delete(); stim_q.delete();

    mst  = (t_mstatus & ~32'h0000_1888) | ((t_mstatus & 32'h8) << 4) | 32'h0000_1800;
    dcs  = (t_dcsr & ~32'h0000_01C3) | (32'(t_dcause) << 6) | 32'h3;
    base = t_mtvec & ~32'h3;
    tgt_a = base;
    tgt_v = (t_mtvec[1:0] == 2'b01) ? base + 32'(t_cause) * 32'd4 : base;
    if (t_kind == 0) begin
      wa.push_back(12'h341); wd.push_back(t_pc & ~32'h1);
      wa.push_back(12'h342); wd.push_back(32'(t_cause));
      wa.push_back(12'h343); wd.push_back(t_info);
      wa.push_back(12'h300); wd.push_back(mst);
    end else if (t_kind == 1) begin
      tgt_a = 32'h0000_0808; tgt_v = 32'h0000_0808;
    end else begin
      wa.push_back(12'h7B1); wd.push_back(t_dpc);
      wa.push_back(12'h7B0); wd.push_back(dcs);
      tgt_a = 32'h0000_0800; tgt_v = 32'h0000_0800;
    end

    o = '0; o.trap_rdy = (t_kind < 2); o.debug_rdy = 1'b1;
    s = '{tv: (t_kind != 2), dv: (t_kind >= 2), crdy: rbit(), rrdy: rbit(), rstn: 1'b1, noise: 1'b0};
    exp_a.push_back(o); exp_v.push_back(o); stim_q.push_back(s);

    o = '0; o.flush = 1'b1; o.busy = 1'b1;
    s = '{tv: rbit(), dv: rbit(), crdy: rbit(), rrdy: rbit(), rstn: 1'b1, noise: 1'b1};
    exp_a.push_back(o); exp_v.push_back(o); stim_q.push_back(s);

    for (int i = 0; i < wa.size(); i++) begin
      for (int unsigned k = 0; k <= wst[i]; k++) begin
        o = '0; o.busy = 1'b1; o.wen = 1'b1; o.waddr = wa[i]; o.wdata = wd[i];
        s = '{tv: rbit(), dv: rbit(), crdy: (k == wst[i]), rrdy: rbit(), rstn: 1'b1, noise: 1'b1};
        exp_a.push_back(o); exp_v.push_back(o); stim_q.push_back(s);
      end
    end

    for (int unsigned k = 0; k <= t_rs; k++) begin
      o = '0; o.busy = 1'b1; o.rvld = 1'b1; o.dms = (t_kind >= 2) && (k == t_rs);
      ov = o;
      o.rpc = tgt_a; ov.rpc = tgt_v;
      s = '{tv: rbit(), dv: rbit(), crdy: rbit(), rrdy: (k == t_rs), rstn: 1'b1, noise: 1'b1};
      exp_a.push_back(o); exp_v.push_back(ov); stim_q.push_back(s);
    end

    if (t_rst_at >= 1 && t_rst_at < stim_q.size()) begin
      while (stim_q.size() > t_rst_at + 1) begin
        void'(stim_q.pop_back()); void'(exp_a.pop_back()); void'(exp_v.pop_back());
      end
      s = stim_q[t_rst_at]; s.rstn = 1'b0; stim_q[t_rst_at] = s;
    end

    o = '0; o.trap_rdy = 1'b1; o.debug_rdy = 1'b1;
    s = '{tv: 1'b0, dv: 1'b0, crdy: rbit(), rrdy: rbit(), rstn: 1'b1, noise: 1'b0};
    exp_a.push_back(o); exp_v.push_back(o); stim_q.push_back(s);

    for (int i = 0; i < stim_q.size(); i++) begin
      @(negedge clk);
      s = stim_q[i];
      trap_vld = s.tv; debug_vld = s.dv; csr_wr_rdy = s.crdy; redirect_rdy = s.rrdy; rst_n = s.rstn;
      csr_mtvec = t_mtvec; csr_mstatus = t_mstatus; csr_dcsr = t_dcsr;
      if (s.noise) begin
        trap_pc = $urandom; trap_cause = 6'($urandom); trap_extra_info = $urandom;
        trap_indebug = rbit(); debug_cause = 3'($urandom); debug_pc = $urandom;
      end else begin
        trap_pc = t_pc; trap_cause = t_cause; trap_extra_info = t_info;
        trap_indebug = (t_kind == 1); debug_cause = t_dcause; debug_pc = t_dpc;
      end
      #1;
      o = sample_a(); ov = sample_v();
      vectors += 2;
      assert (o === exp_a[i]) else begin
        miscompares++;
        $error("FAIL %s cyc%0d scalar: got %h expected %h", name, i, o, exp_a[i]);
      end
      assert (ov === exp_v[i]) else begin
        miscompares++;
        $error("FAIL %s cyc%0d vectored: got %h expected %h", name, i, ov, exp_v[i]);
      end
    end
  endtask

  initial begin
    obs_t o_idle, o;
    rst_n = 1'b0; trap_vld = 1'b0; debug_vld = 1'b0; trap_indebug = 1'b0;
    csr_wr_rdy = 1'b0; redirect_rdy = 1'b0;
    trap_pc = '0; trap_cause = '0; trap_extra_info = '0; debug_cause = '0; debug_pc = '0;
    csr_mtvec = '0; csr_mstatus = '0; csr_dcsr = '0;
    repeat (3) @(negedge clk);
    #1;
    o_idle = '0; o_idle.trap_rdy = 1'b1; o_idle.debug_rdy = 1'b1;
    o = sample_a();
    vectors++;
    assert (o === o_idle) else begin
      miscompares++;
      $error("FAIL reset_state: got %h expected %h", o, o_idle);
    end
    rst_n = 1'b1;

    set_txn(0, 32'h8000_0104, 6'd2, 32'hDEAD_BEEF, 3'd0, 32'h0, 32'h8000_1000, 32'h8, 32'h0);
    run_txn("trap_basic");
    set_txn(0, 32'h8000_0104, 6'd2, 32'hDEAD_BEEF, 3'd0, 32'h0, 32'h8000_1001, 32'h8, 32'h0);
    run_txn("trap_vectored");
    set_txn(3, 32'h1234_5678, 6'd5, 32'h0, 3'd3, 32'h0000_0200, 32'h8000_1000, 32'h8, 32'h4000_0000);
    run_txn("debug_vs_trap");
    set_txn(1, 32'h8000_0200, 6'd3, 32'h55, 3'd0, 32'h0, 32'h8000_1000, 32'h8, 32'h0);
    run_txn("trap_indebug");
    set_txn(0, 32'h8000_0104, 6'd2, 32'hDEAD_BEEF, 3'd0, 32'h0, 32'h8000_1000, 32'h8, 32'h0);
    wst[1] = 3; t_rs = 2;
    run_txn("stalls");
    set_txn(0, 32'h8000_0104, 6'd2, 32'hDEAD_BEEF, 3'd0, 32'h0, 32'h8000_1000, 32'h8, 32'h0);
    t_rst_at = 4;
    run_txn("reset_in_tval");
    set_txn(0, 32'h8000_0333, 6'd11, 32'hCAFE_F00D, 3'd0, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0);
    run_txn("after_reset_wrap");

    for (int n = 0; n < 40; n++) begin
      set_txn($urandom_range(0, 3), $urandom, 6'($urandom), $urandom, 3'($urandom), $urandom,
              $urandom, $urandom, $urandom);
      if (rbit()) t_mtvec[1:0] = 2'b01;
      for (int i = 0; i < 4; i++) wst[i] = $urandom_range(0, 3);
      t_rs = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) t_rst_at = $urandom_range(1, 6);
      run_txn($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
